// File: rtl/cpu_ctrl_fsm.sv
// Control unit for the cpu_8b datapath: fetch/decode/execute sequencing,
// datapath strobes, and a memory request/ready handshake guarded by a watchdog.
module cpu_ctrl_fsm #(
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       zf,
    input  logic       mem_rdy,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       a_ld,
    output logic       a_src,
    output logic       b_ld,
    output logic       alu_op,
    output logic       zf_ld,
    output logic [2:0] state,
    output logic       halt,
    output logic       err
);

    typedef enum logic [2:0] {
        FETCH  = 3'b000,
        DECODE = 3'b001,
        EXEC   = 3'b010,
        HALT   = 3'b100
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'hF;

    // The fault fires in the cycle whose unready edge would bring the count to TIMEOUT.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t          cur_state;
    state_t          next_state;
    logic [TO_W-1:0] wd_cnt;
    logic            wd_fault;
    logic [3:0]      opcode;
    logic            unused_operand;

    assign opcode         = instr[7:4];
    assign unused_operand = ^instr[3:0];
    assign state          = cur_state;
    assign halt           = (cur_state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= FETCH;
            wd_cnt    <= '0;
            err       <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (mem_req && !mem_rdy)
                wd_cnt <= wd_cnt + 1'b1;
            else
                wd_cnt <= '0;
            if (wd_fault)
                err <= 1'b1;
        end
    end

    // Strobes are held at zero while reset is asserted, even though state reads FETCH.
    always_comb begin
        next_state = cur_state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        a_ld       = 1'b0;
        a_src      = 1'b0;
        b_ld       = 1'b0;
        alu_op     = 1'b0;
        zf_ld      = 1'b0;
        wd_fault   = 1'b0;

        if (rst) begin
            case (cur_state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_rdy) begin
                        ir_ld      = 1'b1;
                        pc_inc     = 1'b1;
                        next_state = DECODE;
                    end
                end
                DECODE: next_state = EXEC;
                EXEC: begin
                    case (opcode)
                        OP_LDA: begin
                            mem_req  = 1'b1;
                            addr_sel = 1'b1;
                            if (mem_rdy) begin
                                a_ld       = 1'b1;
                                next_state = FETCH;
                            end
                        end
                        OP_LDB: begin
                            mem_req  = 1'b1;
                            addr_sel = 1'b1;
                            if (mem_rdy) begin
                                b_ld       = 1'b1;
                                next_state = FETCH;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            mem_req  = 1'b1;
                            addr_sel = 1'b1;
                            alu_op   = (opcode == OP_SUB);
                            if (mem_rdy) begin
                                a_ld       = 1'b1;
                                a_src      = 1'b1;
                                zf_ld      = 1'b1;
                                next_state = FETCH;
                            end
                        end
                        OP_STA: begin
                            mem_req  = 1'b1;
                            mem_we   = 1'b1;
                            addr_sel = 1'b1;
                            if (mem_rdy)
                                next_state = FETCH;
                        end
                        OP_JMP: begin
                            pc_ld      = 1'b1;
                            next_state = FETCH;
                        end
                        OP_JZ: begin
                            pc_ld      = zf;
                            next_state = FETCH;
                        end
                        OP_HLT:  next_state = HALT;
                        OP_NOP:  next_state = FETCH;
                        default: next_state = FETCH;
                    endcase
                end
                HALT:    next_state = HALT;
                default: next_state = FETCH;
            endcase

            // A ready in the timeout cycle completes the access instead of faulting.
            if ((TIMEOUT != 0) && mem_req && !mem_rdy && (wd_cnt == TO_LAST)) begin
                wd_fault   = 1'b1;
                next_state = HALT;
            end
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: a vector table of per-cycle inputs and expected
// outputs, plus hand-written watchdog and reset sequences, checked via a queue.
module tb_cpu_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [7:0] instr;
    logic       zf;
    logic       mem_rdy;
    logic       mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld;
    logic       a_ld, a_src, b_ld, alu_op, zf_ld, halt, err;
    logic [2:0] state;
    logic [12:0] outs;

    cpu_ctrl_fsm #(.TIMEOUT(15), .TO_W(4)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zf(zf), .mem_rdy(mem_rdy),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .a_ld(a_ld),
        .a_src(a_src), .b_ld(b_ld), .alu_op(alu_op), .zf_ld(zf_ld),
        .state(state), .halt(halt), .err(err)
    );

    // Bit order: mem_req mem_we addr_sel ir_ld pc_inc pc_ld a_ld a_src b_ld alu_op zf_ld halt err
    assign outs = {mem_req, mem_we, addr_sel, ir_ld, pc_inc, pc_ld,
                   a_ld, a_src, b_ld, alu_op, zf_ld, halt, err};

    localparam logic [12:0] O_NONE  = 13'b0000000000000;
    localparam logic [12:0] O_FETCH = 13'b1001100000000;
    localparam logic [12:0] O_FWAIT = 13'b1000000000000;
    localparam logic [12:0] O_MWAIT = 13'b1010000000000;
    localparam logic [12:0] O_LDA   = 13'b1010001000000;
    localparam logic [12:0] O_LDB   = 13'b1010000010000;
    localparam logic [12:0] O_ADD   = 13'b1010001100100;
    localparam logic [12:0] O_SUB   = 13'b1010001101100;
    localparam logic [12:0] O_STA   = 13'b1110000000000;
    localparam logic [12:0] O_PCLD  = 13'b0000010000000;
    localparam logic [12:0] O_HALT  = 13'b0000000000010;
    localparam logic [12:0] O_FAULT = 13'b0000000000011;

    localparam logic [2:0] S_F = 3'b000, S_D = 3'b001, S_E = 3'b010, S_H = 3'b100;

    typedef struct {
        string      tag;
        logic       rst;
        logic [7:0] instr;
        logic       zf;
        logic       rdy;
        logic [2:0] st;
        logic [12:0] o;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string tag, logic r, logic [7:0] i, logic z,
                                logic rd, logic [2:0] s, logic [12:0] o);
        vec_t v;
        v.tag = tag; v.rst = r; v.instr = i; v.zf = z; v.rdy = rd; v.st = s; v.o = o;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst     = v.rst;
        instr   = v.instr;
        zf      = v.zf;
        mem_rdy = v.rdy;
        sb.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard empty: got nothing, required one entry");
            return;
        end
        e = sb.pop_front();
        checks++;
        if (state !== e.st || outs !== e.o) begin
            errors++;
            $display("[TB] FAIL %s: state got %b req %b, outs got %b req %b",
                     e.tag, state, e.st, outs, e.o);
        end
    endtask

    // One cycle: drive after the rising edge, sample on the falling edge.
    task automatic cycle(input vec_t v);
        @(posedge clk);
        #1;
        applyStimulus(v);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        rst = 1'b0; instr = 8'h00; zf = 1'b0; mem_rdy = 1'b0;

        vecs.push_back(mk("reset0",     0, 8'h00, 0, 1, S_F, O_NONE));
        vecs.push_back(mk("reset1",     0, 8'h00, 0, 1, S_F, O_NONE));
        vecs.push_back(mk("nop_fetch",  1, 8'h00, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("nop_dec",    1, 8'h00, 0, 1, S_D, O_NONE));
        vecs.push_back(mk("nop_exec",   1, 8'h00, 0, 1, S_E, O_NONE));
        vecs.push_back(mk("lda_fetch",  1, 8'h15, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("lda_dec",    1, 8'h15, 0, 1, S_D, O_NONE));
        vecs.push_back(mk("lda_wait1",  1, 8'h15, 0, 0, S_E, O_MWAIT));
        vecs.push_back(mk("lda_wait2",  1, 8'h15, 0, 0, S_E, O_MWAIT));
        vecs.push_back(mk("lda_wait3",  1, 8'h15, 0, 0, S_E, O_MWAIT));
        vecs.push_back(mk("lda_rdy",    1, 8'h15, 0, 1, S_E, O_LDA));
        vecs.push_back(mk("sub_fetch",  1, 8'h44, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("sub_dec",    1, 8'h44, 0, 1, S_D, O_NONE));
        vecs.push_back(mk("sub_exec",   1, 8'h44, 0, 1, S_E, O_SUB));
        vecs.push_back(mk("jz1_fetch",  1, 8'h79, 1, 1, S_F, O_FETCH));
        vecs.push_back(mk("jz1_dec",    1, 8'h79, 1, 1, S_D, O_NONE));
        vecs.push_back(mk("jz1_exec",   1, 8'h79, 1, 1, S_E, O_PCLD));
        vecs.push_back(mk("jz0_fetch",  1, 8'h79, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("jz0_dec",    1, 8'h79, 0, 1, S_D, O_NONE));
        vecs.push_back(mk("jz0_exec",   1, 8'h79, 0, 1, S_E, O_NONE));
        vecs.push_back(mk("add_fwait",  1, 8'h32, 0, 0, S_F, O_FWAIT));
        vecs.push_back(mk("add_fetch",  1, 8'h32, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("add_dec",    1, 8'h32, 0, 1, S_D, O_NONE));
        vecs.push_back(mk("add_exec",   1, 8'h32, 0, 1, S_E, O_ADD));
        vecs.push_back(mk("ldb_fetch",  1, 8'h27, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("ldb_dec",    1, 8'h27, 0, 1, S_D, O_NONE));
        vecs.push_back(mk("ldb_exec",   1, 8'h27, 0, 1, S_E, O_LDB));
        vecs.push_back(mk("sta_fetch",  1, 8'h53, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("sta_dec",    1, 8'h53, 0, 0, S_D, O_NONE));
        vecs.push_back(mk("sta_wait1",  1, 8'h53, 0, 0, S_E, O_STA));
        vecs.push_back(mk("sta_wait2",  1, 8'h53, 0, 0, S_E, O_STA));
        vecs.push_back(mk("sta_rdy",    1, 8'h53, 0, 1, S_E, O_STA));
        vecs.push_back(mk("jmp_fetch",  1, 8'h6A, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("jmp_dec",    1, 8'h6A, 0, 1, S_D, O_NONE));
        vecs.push_back(mk("jmp_exec",   1, 8'h6A, 0, 1, S_E, O_PCLD));
        vecs.push_back(mk("undef_fetch",1, 8'h9C, 1, 1, S_F, O_FETCH));
        vecs.push_back(mk("undef_dec",  1, 8'h9C, 1, 1, S_D, O_NONE));
        vecs.push_back(mk("undef_exec", 1, 8'h9C, 1, 1, S_E, O_NONE));
        vecs.push_back(mk("hlt_fetch",  1, 8'hF0, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("hlt_dec",    1, 8'hF0, 0, 1, S_D, O_NONE));
        vecs.push_back(mk("hlt_exec",   1, 8'hF0, 0, 1, S_E, O_NONE));
        vecs.push_back(mk("halt_hold1", 1, 8'h15, 1, 1, S_H, O_HALT));
        vecs.push_back(mk("halt_hold2", 1, 8'h44, 0, 0, S_H, O_HALT));
        vecs.push_back(mk("halt_rst",   0, 8'h00, 0, 1, S_F, O_NONE));
        vecs.push_back(mk("after_rst",  1, 8'h00, 0, 1, S_F, O_FETCH));
        vecs.push_back(mk("after_dec",  1, 8'h00, 0, 1, S_D, O_NONE));

        for (int i = 0; i < vecs.size(); i++)
            cycle(vecs[i]);

        // Fetch watchdog: 15 unready cycles, then HALT with err.
        cycle(mk("wd_rst", 0, 8'h00, 0, 0, S_F, O_NONE));
        for (int i = 0; i < 15; i++)
            cycle(mk($sformatf("wd_wait%0d", i + 1), 1, 8'h00, 0, 0, S_F, O_FWAIT));
        cycle(mk("wd_fault",  1, 8'h00, 0, 0, S_H, O_FAULT));
        cycle(mk("wd_sticky", 1, 8'h00, 0, 1, S_H, O_FAULT));
        cycle(mk("wd_clr",    0, 8'h00, 0, 0, S_F, O_NONE));

        // Ready arriving in the would-be timeout cycle completes the fetch.
        for (int i = 0; i < 14; i++)
            cycle(mk($sformatf("win_wait%0d", i + 1), 1, 8'h00, 0, 0, S_F, O_FWAIT));
        cycle(mk("win_rdy", 1, 8'h00, 0, 1, S_F, O_FETCH));
        cycle(mk("win_dec", 1, 8'h00, 0, 0, S_D, O_NONE));

        // Exec-phase timeout on a stalled load, then reset mid-access.
        cycle(mk("ewd_exec", 1, 8'h15, 0, 0, S_E, O_MWAIT));
        for (int i = 1; i < 15; i++)
            cycle(mk($sformatf("ewd_wait%0d", i + 1), 1, 8'h15, 0, 0, S_E, O_MWAIT));
        cycle(mk("ewd_fault", 1, 8'h15, 0, 1, S_H, O_FAULT));
        cycle(mk("mid_rst",   0, 8'h00, 0, 0, S_F, O_NONE));
        for (int i = 0; i < 5; i++)
            cycle(mk($sformatf("mid_wait%0d", i + 1), 1, 8'h00, 0, 0, S_F, O_FWAIT));
        cycle(mk("mid_rst2",  0, 8'h00, 0, 0, S_F, O_NONE));
        for (int i = 0; i < 14; i++)
            cycle(mk($sformatf("fresh_wait%0d", i + 1), 1, 8'h00, 0, 0, S_F, O_FWAIT));
        cycle(mk("fresh_rdy", 1, 8'h00, 0, 1, S_F, O_FETCH));

        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: got %0d left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
